gpio_pad_ctrl: RTL and testbench
================================

Name: gpio_pad_ctrl

Overview:
Parametrised pad-control block between the SoC core GPIO/peripheral signals and the chip-top pad ring. It replaces hardwired pad OEN/IE tie-offs with:
- per-pad input synchronisation, optional debounce and edge detection;
- a staged output-enable ramp after reset, which limits simultaneous-switching current;
- an output freeze mode for low-power entry.

It sits in the chip-top wrapper, instantiated once per pad bank.

Parameters:
NUM_PADS, 32, number of pads in the bank (1..64)
SYNC_STAGES, 2, input synchroniser depth (>=2)
DEBOUNCE_W, 8, width of the debounce limit and of each per-pad counter
SEQ_GROUP, 8, pads enabled per ramp step
SEQ_GAP, 16, cycles between ramp steps (>=1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
core_out_i  input  NUM_PADS  output data from core
core_dir_i  input  NUM_PADS  1 = pad is an output
core_in_o  output  NUM_PADS  filtered input data to core
edge_rise_o  output  NUM_PADS  one-cycle rising-edge pulse on filtered input
edge_fall_o  output  NUM_PADS  one-cycle falling-edge pulse on filtered input
debounce_en_i  input  NUM_PADS  per-pad debounce enable
debounce_lim_i  input  DEBOUNCE_W  debounce limit L, shared by all pads
seq_start_i  input  1  start output-enable ramp
freeze_i  input  1  hold pad outputs
seq_done_o  output  1  ramp complete (ACTIVE or FROZEN)
pad_in_i  input  NUM_PADS  raw pad input
pad_out_o  output  NUM_PADS  pad output data
pad_oen_o  output  NUM_PADS  pad output enable, active-low
pad_ie_o  output  NUM_PADS  pad input enable

Behaviour:
- Clocking/reset: single clock clk; reset rst is synchronous, active-high. All flops reset on the rst edge.
- Reset values:
  - pad_out_o=0, pad_oen_o=all 1, pad_ie_o=all 1.
  - core_in_o=0, edge_*=0, seq_done_o=0.
  - Synchronisers, debounce counters and enable mask cleared; state IDLE.
- Reset mid-ramp or mid-freeze returns everything to reset values on the next edge. No partial state survives.
- State machine IDLE -> RAMP -> ACTIVE <-> FROZEN:
  - IDLE: mask=0. On seq_start_i=1 at edge t: state=RAMP, group 0 mask bits set at t+1.
  - RAMP: gap counter runs 0..SEQ_GAP-1. Group k (pads k*SEQ_GROUP .. min((k+1)*SEQ_GROUP, NUM_PADS)-1) is enabled at t+1+k*SEQ_GAP.
  - G = ceil(NUM_PADS/SEQ_GROUP). At t+1+G*SEQ_GAP: state=ACTIVE, seq_done_o=1.
  - seq_start_i is ignored outside IDLE. freeze_i is ignored in IDLE and RAMP.
  - ACTIVE: freeze_i=1 -> FROZEN on the next edge.
  - FROZEN: output registers hold their value. freeze_i=0 -> ACTIVE, and updates resume on the following edge. seq_done_o stays 1 in FROZEN.
- Output stage (registered, 1-cycle latency, updates in every state except FROZEN):
  - pad_out_o <= core_out_i & mask.
  - pad_oen_o <= ~(core_dir_i & mask).
  - pad_ie_o stays all 1.
- Input path, per pad:
  - SYNC_STAGES-flop synchroniser produces s.
  - Filter register f drives core_in_o.
  - debounce_en_i=0: f <= s; counter held at 0.
  - debounce_en_i=1:
    - s==f: counter <= 0.
    - else if counter==L: f <= s, counter <= 0.
    - else: counter++.
  - f therefore changes only after L+1 consecutive differing cycles. L=0 behaves as bypass.
  - Latency from pad_in_i to core_in_o: SYNC_STAGES+1+L cycles (bypass: SYNC_STAGES+1).
  - A single-cycle glitch shorter than L+1 cycles never reaches f.
  - Changing debounce_lim_i mid-count takes effect on the next compare. If the counter is already above the new L, it keeps counting and wraps to 0 at 2^DEBOUNCE_W; f does not update until a later match.
- Edge detection:
  - edge_rise_o and edge_fall_o are registered in the same edge that updates f. The pulse is visible in the first cycle core_in_o shows the new value.
  - Exactly one cycle wide.
  - No edge pulse on the reset edge.

Decomposition:
- Package gpio_pad_pkg:
  - state enum {IDLE, RAMP, ACTIVE, FROZEN};
  - function computing G = ceil(NUM_PADS/SEQ_GROUP);
  - reset-value constants for the pad_oen/pad_ie vectors.
- Sub-module gpio_pad_filter: one pad's synchroniser, debounce counter and edge detector, parametrised by SYNC_STAGES and DEBOUNCE_W. Generated NUM_PADS times.
- The top level holds the FSM, gap/group counters, mask and output registers.

Test Plan:
- Reset check: assert rst for 3 cycles with random inputs -> pad_oen_o=32'hFFFF_FFFF, pad_out_o=0, pad_ie_o=all 1, core_in_o=0, seq_done_o=0, no edge pulses.
- Ramp timing: core_dir_i=all 1, core_out_i=32'hA5A5_A5A5, defaults, seq_start_i at cycle t -> pad_oen_o[7:0]=0 at t+2, [15:8]=0 at t+18, [23:16]=0 at t+34, [31:24]=0 at t+50; seq_done_o=1 at t+65; pad_out_o=32'hA5A5_A5A5 at t+51.
- Bypass path: debounce_en_i=0, pad_in_i[3] rises at cycle c -> core_in_o[3]=1 and edge_rise_o[3]=1 at c+3; edge_rise_o[3]=0 at c+4.
- Debounce: en=1, L=4. A 4-cycle high pulse on pad_in_i[5] -> core_in_o[5] stays 0, no edge. A 5-cycle-stable rise at cycle c -> core_in_o[5]=1 at c+7.
- Freeze: in ACTIVE, freeze_i=1, then toggle core_out_i for 10 cycles -> pad_out_o/pad_oen_o unchanged. freeze_i=0 at cycle d -> new values visible at d+2. seq_start_i pulses during FROZEN are ignored.
- Reset mid-ramp: rst at t+20 of a ramp -> pad_oen_o all 1 next cycle, state IDLE. A new seq_start_i restarts from group 0.

Source files
------------

// File: rtl/gpio_pad_pkg.sv
// Shared types and constants for the GPIO pad-control bank.
//   pad_state_e    : output-enable sequencer states
//   group_count()  : number of ramp groups needed to cover a bank
//   PAD_OEN_RST    : pad output-enable value held during reset (all disabled)
//   PAD_IE_RST     : pad input-enable value (inputs always enabled)
package gpio_pad_pkg;

  // Largest bank supported by one instance.
  localparam int MAX_PADS = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAMP   = 2'd1,
    ACTIVE = 2'd2,
    FROZEN = 2'd3
  } pad_state_e;

  // Active-low OEN, so every pad stays tri-stated out of reset.
  localparam logic [MAX_PADS-1:0] PAD_OEN_RST = '1;
  localparam logic [MAX_PADS-1:0] PAD_IE_RST  = '1;

  // Ceiling division: a short final group still needs its own ramp step.
  function automatic int group_count(input int num_pads, input int seq_group);
    return (num_pads + seq_group - 1) / seq_group;
  endfunction

endpackage

// File: rtl/gpio_pad_ctrl_if.sv
// Bundle of all non-clock signals of one pad bank.
//   core side : core_out_i, core_dir_i, core_in_o, edge_rise_o, edge_fall_o,
//               debounce_en_i, debounce_lim_i, seq_start_i, freeze_i, seq_done_o
//   pad side  : pad_in_i, pad_out_o, pad_oen_o, pad_ie_o
// slave  : the pad-control block itself
// master : whoever drives the block (core wrapper or testbench)
interface gpio_pad_ctrl_if #(
  parameter int NUM_PADS   = 32,
  parameter int DEBOUNCE_W = 8
);

  logic [NUM_PADS-1:0]   core_out_i;
  logic [NUM_PADS-1:0]   core_dir_i;
  logic [NUM_PADS-1:0]   core_in_o;
  logic [NUM_PADS-1:0]   edge_rise_o;
  logic [NUM_PADS-1:0]   edge_fall_o;
  logic [NUM_PADS-1:0]   debounce_en_i;
  logic [DEBOUNCE_W-1:0] debounce_lim_i;
  logic                  seq_start_i;
  logic                  freeze_i;
  logic                  seq_done_o;
  logic [NUM_PADS-1:0]   pad_in_i;
  logic [NUM_PADS-1:0]   pad_out_o;
  logic [NUM_PADS-1:0]   pad_oen_o;
  logic [NUM_PADS-1:0]   pad_ie_o;

  modport master (
    output core_out_i, core_dir_i, debounce_en_i, debounce_lim_i,
           seq_start_i, freeze_i, pad_in_i,
    input  core_in_o, edge_rise_o, edge_fall_o, seq_done_o,
           pad_out_o, pad_oen_o, pad_ie_o
  );

  modport slave (
    input  core_out_i, core_dir_i, debounce_en_i, debounce_lim_i,
           seq_start_i, freeze_i, pad_in_i,
    output core_in_o, edge_rise_o, edge_fall_o, seq_done_o,
           pad_out_o, pad_oen_o, pad_ie_o
  );

endinterface

// File: rtl/gpio_pad_filter.sv
// Input conditioning for a single pad: synchroniser, optional debounce
// filter and registered edge detector.
//   clk, rst : clock, synchronous active-high reset
//   pad_i    : raw asynchronous pad input
//   en_i     : debounce enable (0 = filter follows the synchroniser)
//   lim_i    : debounce limit L; a change is accepted after L+1 differing cycles
//   filt_o   : filtered level
//   rise_o   : one-cycle pulse when filt_o goes 0 -> 1
//   fall_o   : one-cycle pulse when filt_o goes 1 -> 0
module gpio_pad_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pad_i,
  input  logic                  en_i,
  input  logic [DEBOUNCE_W-1:0] lim_i,
  output logic                  filt_o,
  output logic                  rise_o,
  output logic                  fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   filt_q, filt_d;
  logic [DEBOUNCE_W-1:0]  cnt_q, cnt_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sync_lvl;

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  // The counter only ever compares for equality with L, so lowering L below
  // a running count lets it run on and wrap before it can match again.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pad_i};
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (!en_i) begin
      filt_d = sync_lvl;
      cnt_d  = '0;
    end else if (sync_lvl == filt_q) begin
      cnt_d  = '0;
    end else if (cnt_q == lim_i) begin
      filt_d = sync_lvl;
      cnt_d  = '0;
    end else begin
      cnt_d  = cnt_q + DEBOUNCE_W'(1);
    end
    rise_d = filt_d & ~filt_q;
    fall_d = ~filt_d & filt_q;
  end

  // Edge flags are registered alongside the filter so a pulse lines up with
  // the first cycle the new level is visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign filt_o = filt_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/gpio_pad_ctrl.sv
// Pad-control block for one pad bank. Conditions pad inputs toward the core
// and drives pad outputs with a staged output-enable ramp and a freeze mode.
//   clk, rst : clock, synchronous active-high reset
//   bus      : gpio_pad_ctrl_if slave modport carrying all core-side and
//              pad-side signals (data, direction, debounce controls,
//              seq_start/freeze/seq_done, pad in/out/oen/ie)
module gpio_pad_ctrl
  import gpio_pad_pkg::*;
#(
  parameter int NUM_PADS    = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_W  = 8,
  parameter int SEQ_GROUP   = 8,
  parameter int SEQ_GAP     = 16
) (
  input  logic           clk,
  input  logic           rst,
  gpio_pad_ctrl_if.slave bus
);

  localparam int G_CNT = group_count(NUM_PADS, SEQ_GROUP);
  localparam int GRP_W = $clog2(G_CNT + 1);
  localparam int GAP_W = (SEQ_GAP > 1) ? $clog2(SEQ_GAP) : 1;

  localparam logic [GRP_W-1:0] GRP_DONE = GRP_W'(G_CNT);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SEQ_GAP - 1);

  pad_state_e          state_q, state_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [GRP_W-1:0]    grp_q, grp_d;
  logic [NUM_PADS-1:0] mask_q, mask_d;
  logic [NUM_PADS-1:0] pad_out_q, pad_out_d;
  logic [NUM_PADS-1:0] pad_oen_q, pad_oen_d;
  logic [NUM_PADS-1:0] grp_mask;
  logic [NUM_PADS-1:0] filt_vec, rise_vec, fall_vec;
  int                  grp_lo;

  // Per-pad input conditioning.
  for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
    gpio_pad_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE_W  (DEBOUNCE_W)
    ) u_filter (
      .clk    (clk),
      .rst    (rst),
      .pad_i  (bus.pad_in_i[i]),
      .en_i   (bus.debounce_en_i[i]),
      .lim_i  (bus.debounce_lim_i),
      .filt_o (filt_vec[i]),
      .rise_o (rise_vec[i]),
      .fall_o (fall_vec[i])
    );
  end

  // Pads belonging to the group currently being enabled; the last group may
  // be short, which the loop bound takes care of.
  always_comb begin
    grp_lo   = int'(grp_q) * SEQ_GROUP;
    grp_mask = '0;
    for (int i = 0; i < NUM_PADS; i++) begin
      grp_mask[i] = (i >= grp_lo) && (i < grp_lo + SEQ_GROUP);
    end
  end

  // Sequencer: each ramp step opens on gap==0, so group k is enabled
  // k*SEQ_GAP cycles after group 0, and the step after the last group
  // finishes the ramp.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    grp_d   = grp_q;
    mask_d  = mask_q;
    unique case (state_q)
      IDLE: begin
        mask_d = '0;
        if (bus.seq_start_i) begin
          state_d = RAMP;
          gap_d   = '0;
          grp_d   = '0;
        end
      end
      RAMP: begin
        if (gap_q == '0) begin
          if (grp_q == GRP_DONE) begin
            state_d = ACTIVE;
          end else begin
            mask_d = mask_q | grp_mask;
          end
        end
        if (gap_q == GAP_LAST) begin
          gap_d = '0;
          grp_d = grp_q + GRP_W'(1);
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      ACTIVE: begin
        if (bus.freeze_i) state_d = FROZEN;
      end
      FROZEN: begin
        if (!bus.freeze_i) state_d = ACTIVE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output stage follows the core through the current mask except while
  // frozen, when the pads keep whatever they last drove.
  always_comb begin
    pad_out_d = pad_out_q;
    pad_oen_d = pad_oen_q;
    if (state_q != FROZEN) begin
      pad_out_d = bus.core_out_i & mask_q;
      pad_oen_d = ~(bus.core_dir_i & mask_q);
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gap_q     <= '0;
      grp_q     <= '0;
      mask_q    <= '0;
      pad_out_q <= '0;
      pad_oen_q <= PAD_OEN_RST[NUM_PADS-1:0];
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      grp_q     <= grp_d;
      mask_q    <= mask_d;
      pad_out_q <= pad_out_d;
      pad_oen_q <= pad_oen_d;
    end
  end

  assign bus.core_in_o   = filt_vec;
  assign bus.edge_rise_o = rise_vec;
  assign bus.edge_fall_o = fall_vec;
  assign bus.pad_out_o   = pad_out_q;
  assign bus.pad_oen_o   = pad_oen_q;
  assign bus.pad_ie_o    = PAD_IE_RST[NUM_PADS-1:0];
  assign bus.seq_done_o  = (state_q == ACTIVE) || (state_q == FROZEN);

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Self-checking bench for gpio_pad_ctrl: directed steps plus randomized
// traffic, every cycle compared against a behavioural model of the bank.
module tb_gpio_pad_ctrl;

  localparam int NP    = 32;
  localparam int SYNC  = 2;
  localparam int DW    = 8;
  localparam int GROUP = 8;
  localparam int GAP   = 16;
  localparam int G     = (NP + GROUP - 1) / GROUP;

  logic clk = 1'b0;
  logic rst = 1'b1;

  gpio_pad_ctrl_if #(.NUM_PADS(NP), .DEBOUNCE_W(DW)) bus ();

  gpio_pad_ctrl #(
    .NUM_PADS    (NP),
    .SYNC_STAGES (SYNC),
    .DEBOUNCE_W  (DW),
    .SEQ_GROUP   (GROUP),
    .SEQ_GAP     (GAP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model: state is tracked by phase and edges-since-start,
  // the mask is derived arithmetically from that count.
  typedef enum {M_IDLE, M_RAMP, M_ACTIVE, M_FROZEN} mstate_t;
  mstate_t        m_state;
  int             m_n;
  logic [NP-1:0]  m_out, m_oen, m_f, m_rise, m_fall;
  logic           m_done;
  int             m_run [NP];
  logic [NP-1:0]  m_hist [$];

  function logic [NP-1:0] model_mask();
    int groups;
    int bits;
    logic [63:0] ones;
    if (m_state == M_IDLE) return '0;
    if (m_state == M_ACTIVE || m_state == M_FROZEN) return '1;
    if (m_n == 0) return '0;
    groups = (m_n - 1) / GAP + 1;
    if (groups > G) groups = G;
    bits = groups * GROUP;
    if (bits > NP) bits = NP;
    ones = (64'd1 << bits) - 64'd1;
    return ones[NP-1:0];
  endfunction

  function void model_step();
    logic [NP-1:0] mask;
    logic [NP-1:0] s;
    logic [NP-1:0] old;
    if (rst) begin
      m_state = M_IDLE;
      m_n     = 0;
      m_out   = '0;
      m_oen   = '1;
      m_f     = '0;
      m_rise  = '0;
      m_fall  = '0;
      for (int i = 0; i < NP; i++) m_run[i] = 0;
      m_hist.delete();
      for (int i = 0; i < SYNC; i++) m_hist.push_back('0);
    end else begin
      mask = model_mask();
      if (m_state != M_FROZEN) begin
        m_out = bus.core_out_i & mask;
        m_oen = ~(bus.core_dir_i & mask);
      end
      case (m_state)
        M_IDLE:   if (bus.seq_start_i) begin m_state = M_RAMP; m_n = 0; end
        M_RAMP:   begin
                    m_n++;
                    if (m_n >= 1 + G * GAP) m_state = M_ACTIVE;
                  end
        M_ACTIVE: if (bus.freeze_i) m_state = M_FROZEN;
        M_FROZEN: if (!bus.freeze_i) m_state = M_ACTIVE;
        default:  m_state = M_IDLE;
      endcase
      s = m_hist[SYNC-1];
      m_hist.push_front(bus.pad_in_i);
      void'(m_hist.pop_back());
      old = m_f;
      for (int i = 0; i < NP; i++) begin
        if (!bus.debounce_en_i[i]) begin
          m_f[i]   = s[i];
          m_run[i] = 0;
        end else if (s[i] == m_f[i]) begin
          m_run[i] = 0;
        end else begin
          m_run[i]++;
          if (m_run[i] == int'(bus.debounce_lim_i) + 1) begin
            m_f[i]   = s[i];
            m_run[i] = 0;
          end
        end
      end
      m_rise = m_f & ~old;
      m_fall = ~m_f & old;
    end
    m_done = (m_state == M_ACTIVE) || (m_state == M_FROZEN);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    chk("core_in",   bus.core_in_o,        m_f);
    chk("edge_rise", bus.edge_rise_o,      m_rise);
    chk("edge_fall", bus.edge_fall_o,      m_fall);
    chk("pad_out",   bus.pad_out_o,        m_out);
    chk("pad_oen",   bus.pad_oen_o,        m_oen);
    chk("pad_ie",    bus.pad_ie_o,         32'hFFFF_FFFF);
    chk("seq_done",  32'(bus.seq_done_o),  32'(m_done));
  endtask

  // One clock: model advances on the edge, outputs compared 1 time unit later.
  task automatic applyStimulus();
    @(posedge clk);
    model_step();
    #1;
    checkOutput();
  endtask

  task automatic run_ramp(input int len);
    bus.seq_start_i = 1'b1;
    applyStimulus();
    bus.seq_start_i = 1'b0;
    for (int j = 1; j <= len; j++) begin
      applyStimulus();
      if (j == 1)  chk("ramp_oen_t1",  bus.pad_oen_o, 32'hFFFF_FFFF);
      if (j == 2)  chk("ramp_oen_g0",  bus.pad_oen_o, 32'hFFFF_FF00);
      if (j == 2)  chk("ramp_out_g0",  bus.pad_out_o, 32'h0000_00A5);
      if (j == 17) chk("ramp_oen_pre1", bus.pad_oen_o, 32'hFFFF_FF00);
      if (j == 18) chk("ramp_oen_g1",  bus.pad_oen_o, 32'hFFFF_0000);
      if (j == 34) chk("ramp_oen_g2",  bus.pad_oen_o, 32'hFF00_0000);
      if (j == 50) chk("ramp_oen_g3",  bus.pad_oen_o, 32'h0000_0000);
      if (j == 51) chk("ramp_out_all", bus.pad_out_o, 32'hA5A5_A5A5);
      if (j == 64) chk("ramp_done_pre", 32'(bus.seq_done_o), 32'd0);
      if (j == 65) chk("ramp_done",    32'(bus.seq_done_o), 32'd1);
    end
  endtask

  logic [NP-1:0] held_out, held_oen, last_out, last_dir;

  initial begin
    bus.core_out_i     = $urandom;
    bus.core_dir_i     = $urandom;
    bus.debounce_en_i  = $urandom;
    bus.debounce_lim_i = DW'($urandom);
    bus.seq_start_i    = 1'b1;
    bus.freeze_i       = 1'b1;
    bus.pad_in_i       = $urandom;
    rst                = 1'b1;

    // Reset with random inputs.
    for (int j = 0; j < 3; j++) begin
      applyStimulus();
      chk("rst_oen",  bus.pad_oen_o, 32'hFFFF_FFFF);
      chk("rst_out",  bus.pad_out_o, 32'h0);
      chk("rst_in",   bus.core_in_o, 32'h0);
      chk("rst_rise", bus.edge_rise_o | bus.edge_fall_o, 32'h0);
      bus.core_out_i = $urandom;
      bus.pad_in_i   = $urandom;
    end

    // Ramp with defaults.
    rst                = 1'b0;
    bus.core_dir_i     = '1;
    bus.core_out_i     = 32'hA5A5_A5A5;
    bus.debounce_en_i  = '0;
    bus.debounce_lim_i = '0;
    bus.seq_start_i    = 1'b0;
    bus.freeze_i       = 1'b0;
    bus.pad_in_i       = '0;
    for (int j = 0; j < 4; j++) applyStimulus();
    run_ramp(70);

    // Bypass path on pad 3.
    bus.pad_in_i[3] = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      applyStimulus();
      if (j == 2) chk("byp_in_early", 32'(bus.core_in_o[3]), 32'd0);
      if (j == 3) chk("byp_in",       32'(bus.core_in_o[3]), 32'd1);
      if (j == 3) chk("byp_rise",     32'(bus.edge_rise_o[3]), 32'd1);
      if (j == 4) chk("byp_rise_end", 32'(bus.edge_rise_o[3]), 32'd0);
    end

    // Debounce on pad 5, L=4: short pulse rejected, stable rise accepted.
    bus.debounce_en_i[5] = 1'b1;
    bus.debounce_lim_i   = 8'd4;
    for (int j = 0; j < 5; j++) applyStimulus();
    bus.pad_in_i[5] = 1'b1;
    for (int j = 0; j < 4; j++) applyStimulus();
    bus.pad_in_i[5] = 1'b0;
    for (int j = 0; j < 12; j++) begin
      applyStimulus();
      chk("deb_glitch_in",   32'(bus.core_in_o[5]),   32'd0);
      chk("deb_glitch_rise", 32'(bus.edge_rise_o[5]), 32'd0);
    end
    bus.pad_in_i[5] = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      applyStimulus();
      if (j == 6) chk("deb_in_early", 32'(bus.core_in_o[5]),   32'd0);
      if (j == 7) chk("deb_in",       32'(bus.core_in_o[5]),   32'd1);
      if (j == 7) chk("deb_rise",     32'(bus.edge_rise_o[5]), 32'd1);
      if (j == 8) chk("deb_rise_end", 32'(bus.edge_rise_o[5]), 32'd0);
    end

    // Freeze: outputs hold, seq_start ignored, updates resume after release.
    bus.core_out_i = $urandom;
    bus.core_dir_i = $urandom;
    bus.freeze_i   = 1'b1;
    applyStimulus();
    held_out = m_out;
    held_oen = m_oen;
    for (int j = 0; j < 10; j++) begin
      bus.core_out_i  = $urandom;
      bus.core_dir_i  = $urandom;
      bus.seq_start_i = j[0];
      applyStimulus();
      chk("frz_out",  bus.pad_out_o, held_out);
      chk("frz_oen",  bus.pad_oen_o, held_oen);
      chk("frz_done", 32'(bus.seq_done_o), 32'd1);
    end
    bus.seq_start_i = 1'b0;
    last_out        = $urandom;
    last_dir        = $urandom;
    bus.core_out_i  = last_out;
    bus.core_dir_i  = last_dir;
    bus.freeze_i    = 1'b0;
    applyStimulus();
    chk("unfrz_hold", bus.pad_out_o, held_out);
    applyStimulus();
    chk("unfrz_out", bus.pad_out_o, last_out);
    chk("unfrz_oen", bus.pad_oen_o, ~last_dir);

    // Randomized traffic; L only changes after inputs have been quiet.
    for (int seg = 0; seg < 4; seg++) begin
      bus.freeze_i = 1'b0;
      for (int j = 0; j < 20; j++) applyStimulus();
      bus.debounce_lim_i = DW'($urandom_range(0, 6));
      bus.debounce_en_i  = $urandom;
      for (int j = 0; j < 80; j++) begin
        bus.pad_in_i      = bus.pad_in_i ^ ($urandom & $urandom & $urandom);
        bus.debounce_en_i = bus.debounce_en_i ^ ($urandom & $urandom & $urandom & $urandom);
        bus.core_out_i    = $urandom;
        bus.core_dir_i    = $urandom;
        bus.freeze_i      = ($urandom_range(0, 3) == 0);
        bus.seq_start_i   = ($urandom_range(0, 7) == 0);
        applyStimulus();
      end
    end

    // Reset mid-ramp, then a fresh ramp from group 0.
    bus.seq_start_i = 1'b0;
    bus.freeze_i    = 1'b0;
    rst             = 1'b1;
    applyStimulus();
    applyStimulus();
    rst             = 1'b0;
    bus.core_dir_i  = '1;
    bus.core_out_i  = 32'hA5A5_A5A5;
    run_ramp(20);
    rst            = 1'b1;
    bus.core_out_i = $urandom;
    bus.pad_in_i   = $urandom;
    applyStimulus();
    chk("midrst_oen",  bus.pad_oen_o, 32'hFFFF_FFFF);
    chk("midrst_out",  bus.pad_out_o, 32'h0);
    chk("midrst_done", 32'(bus.seq_done_o), 32'd0);
    rst            = 1'b0;
    bus.core_out_i = 32'hA5A5_A5A5;
    bus.pad_in_i   = '0;
    applyStimulus();
    run_ramp(70);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
